// File: rtl/fft_frame_sink.sv
// ---------------------------------------------------------------------------
// fft_frame_sink
//
// Receive-side companion of the FFT input framer. Accepts AXI-Stream result
// frames from the FFT/IFFT core, checks each frame length against FFT_LEN,
// buffers complete frames store-and-forward and emits them as split I/Q
// samples behind a valid/ready handshake.
//
// Build option:
//   FRAME_ERR_DROP_EN  defined   -> a frame with a length error is rolled back
//                                   and never reaches the output.
//                      undefined -> a frame with a length error is committed
//                                   as received, closed with last=1.
//
// Ports:
//   SYS_CLK         in   single clock
//   SYS_RSTN        in   synchronous active-low reset
//   S_TDATA         in   beat from core, I = [BIT_NUM-1:0], Q = upper half
//   S_TVALID        in   beat valid
//   S_TLAST         in   core end-of-frame marker
//   S_TREADY        out  sink can accept a beat (registered)
//   OUT_READY       in   downstream accepts the output sample
//   I_DATA_OUT      out  real component
//   Q_DATA_OUT      out  imaginary component
//   DATA_OUT_VALID  out  output sample valid
//   DATA_OUT_LAST   out  output sample closes a frame
//   FRAME_DONE      out  one-cycle pulse, good frame committed
//   FRAME_ERR       out  one-cycle pulse, frame length error detected
//   FRAME_CNT       out  good frames committed, saturating
// ---------------------------------------------------------------------------
module fft_frame_sink #(
    parameter int BIT_NUM    = 24,
    parameter int FFT_LEN    = 512,
    parameter int FIFO_DEPTH = 1024
) (
    input  logic                 SYS_CLK,
    input  logic                 SYS_RSTN,
    input  logic [2*BIT_NUM-1:0] S_TDATA,
    input  logic                 S_TVALID,
    input  logic                 S_TLAST,
    output logic                 S_TREADY,
    input  logic                 OUT_READY,
    output logic [BIT_NUM-1:0]   I_DATA_OUT,
    output logic [BIT_NUM-1:0]   Q_DATA_OUT,
    output logic                 DATA_OUT_VALID,
    output logic                 DATA_OUT_LAST,
    output logic                 FRAME_DONE,
    output logic                 FRAME_ERR,
    output logic [15:0]          FRAME_CNT
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;               // extra bit tells full from empty
    localparam int CW = $clog2(FFT_LEN);
    localparam int EW = 2 * BIT_NUM + 1;      // {last, Q, I}

    localparam logic [CW-1:0] CNT_LAST = CW'(FFT_LEN - 1);
    localparam logic [PW-1:0] DEPTH_P  = PW'(FIFO_DEPTH);

    typedef enum logic {
        RECV   = 1'b0,
        RESYNC = 1'b1
    } state_t;

    logic [EW-1:0]      mem [FIFO_DEPTH];

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [PW-1:0]      wr_q, wr_d;
    logic [PW-1:0]      cmt_q, cmt_d;
    logic [PW-1:0]      rd_q, rd_d;
    logic               tready_q, tready_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [15:0]        fcnt_q, fcnt_d;
    logic [BIT_NUM-1:0] i_q, q_q;
    logic               valid_q, last_q;

    logic               beat_acc;
    logic               cnt_end;
    logic               mem_we;
    logic               out_load;
    logic [PW-1:0]      wr_inc;
    logic [PW-1:0]      fill_d;
    logic [EW-1:0]      mem_rdata;

    assign beat_acc  = S_TVALID && tready_q;
    assign cnt_end   = (cnt_q == CNT_LAST);
    assign wr_inc    = wr_q + 1'b1;
    assign mem_rdata = mem[rd_q[AW-1:0]];

    // Only committed beats (below cmt_q) may leave; the output register
    // refills whenever it is empty or being consumed this cycle.
    assign out_load  = (rd_q != cmt_q) && (!valid_q || OUT_READY);

    // NOTE: every variable of a combinational block gets a default before any
    // branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        cmt_d   = cmt_q;
        rd_d    = rd_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        fcnt_d  = fcnt_q;
        mem_we  = 1'b0;

        if (beat_acc) begin
            unique case (state_q)
                RECV: begin
                    mem_we = 1'b1;
                    wr_d   = wr_inc;
                    if (cnt_end && S_TLAST) begin
                        cmt_d  = wr_inc;
                        done_d = 1'b1;
                        cnt_d  = '0;
                        if (fcnt_q != 16'hFFFF) begin
                            fcnt_d = fcnt_q + 16'd1;
                        end
                    end else if (S_TLAST || cnt_end) begin
                        // Early last, or missing last at the expected length.
                        err_d = 1'b1;
                        cnt_d = '0;
                        if (!S_TLAST) begin
                            state_d = RESYNC;
                        end
`ifdef FRAME_ERR_DROP_EN
                        wr_d = cmt_q;
`else
                        cmt_d = wr_inc;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RESYNC: begin
                    if (S_TLAST) begin
                        state_d = RECV;
                    end
                end
                default: state_d = RECV;
            endcase
        end

        if (out_load) begin
            rd_d = rd_q + 1'b1;
        end
    end

    // Ready is registered from the next-cycle pointers: a read in the same
    // cycle as a full buffer only reopens the input one cycle later.
    assign fill_d   = wr_d - rd_d;
    assign tready_d = (state_d == RESYNC) || (fill_d < DEPTH_P);

    // NOTE: the sample buffer has no reset; stale contents are never visible
    // because the pointers, which are reset, gate every read.
    always_ff @(posedge SYS_CLK) begin
        if (mem_we) begin
            mem[wr_q[AW-1:0]] <= {S_TLAST | cnt_end, S_TDATA};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge SYS_CLK) begin
        if (!SYS_RSTN) begin
            state_q  <= RECV;
            cnt_q    <= '0;
            wr_q     <= '0;
            cmt_q    <= '0;
            rd_q     <= '0;
            tready_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            fcnt_q   <= '0;
            i_q      <= '0;
            q_q      <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            cmt_q    <= cmt_d;
            rd_q     <= rd_d;
            tready_q <= tready_d;
            done_q   <= done_d;
            err_q    <= err_d;
            fcnt_q   <= fcnt_d;
            if (out_load) begin
                {last_q, q_q, i_q} <= mem_rdata;
                valid_q            <= 1'b1;
            end else if (OUT_READY) begin
                // Consumed with nothing committed behind it; data is held.
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

    assign S_TREADY       = tready_q;
    assign I_DATA_OUT     = i_q;
    assign Q_DATA_OUT     = q_q;
    assign DATA_OUT_VALID = valid_q;
    assign DATA_OUT_LAST  = last_q;
    assign FRAME_DONE     = done_q;
    assign FRAME_ERR      = err_q;
    assign FRAME_CNT      = fcnt_q;

endmodule

// File: tb/tb_fft_frame_sink.sv
// ---------------------------------------------------------------------------
// tb_fft_frame_sink
//
// Directed bench for fft_frame_sink with its default parameters. Beats carry
// {Q = v, I = -v}; expected output sequences are built by the bench from the
// frames it sends and compared against what a negedge monitor collects.
// ---------------------------------------------------------------------------
module tb_fft_frame_sink;

    localparam int BN = 24;
    localparam int FL = 512;
    localparam int FD = 1024;

    typedef logic [2*BN:0] samp_t;   // {last, Q, I}

    logic            SYS_CLK;
    logic            SYS_RSTN;
    logic [2*BN-1:0] S_TDATA;
    logic            S_TVALID;
    logic            S_TLAST;
    logic            S_TREADY;
    logic            OUT_READY;
    logic [BN-1:0]   I_DATA_OUT;
    logic [BN-1:0]   Q_DATA_OUT;
    logic            DATA_OUT_VALID;
    logic            DATA_OUT_LAST;
    logic            FRAME_DONE;
    logic            FRAME_ERR;
    logic [15:0]     FRAME_CNT;

    fft_frame_sink #(
        .BIT_NUM    (BN),
        .FFT_LEN    (FL),
        .FIFO_DEPTH (FD)
    ) dut (
        .SYS_CLK        (SYS_CLK),
        .SYS_RSTN       (SYS_RSTN),
        .S_TDATA        (S_TDATA),
        .S_TVALID       (S_TVALID),
        .S_TLAST        (S_TLAST),
        .S_TREADY       (S_TREADY),
        .OUT_READY      (OUT_READY),
        .I_DATA_OUT     (I_DATA_OUT),
        .Q_DATA_OUT     (Q_DATA_OUT),
        .DATA_OUT_VALID (DATA_OUT_VALID),
        .DATA_OUT_LAST  (DATA_OUT_LAST),
        .FRAME_DONE     (FRAME_DONE),
        .FRAME_ERR      (FRAME_ERR),
        .FRAME_CNT      (FRAME_CNT)
    );

    initial SYS_CLK = 1'b0;
    always #5 SYS_CLK = ~SYS_CLK;

    int    checks     = 0;
    int    failures   = 0;
    int    done_cnt   = 0;
    int    err_cnt    = 0;
    int    acc_cnt    = 0;
    int    exp_frames = 0;
    samp_t obs_q[$];
    samp_t exp_q[$];

    // Inputs change at posedge+1, so at the negedge both sides of every
    // handshake are stable and describe the transfer of the next edge.
    always @(negedge SYS_CLK) begin
        if (SYS_RSTN) begin
            if (DATA_OUT_VALID && OUT_READY) obs_q.push_back({DATA_OUT_LAST, Q_DATA_OUT, I_DATA_OUT});
            if (S_TVALID && S_TREADY) acc_cnt++;
            if (FRAME_DONE) done_cnt++;
            if (FRAME_ERR) err_cnt++;
        end
    end

    function automatic logic [2*BN-1:0] mk(input int v);
        logic [BN-1:0] iv;
        logic [BN-1:0] qv;
        qv = BN'(v);
        iv = BN'(-v);
        return {qv, iv};
    endfunction

    // Index of the first disagreement between observed and expected, or -1.
    function automatic int first_diff();
        int n;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (obs_q[i] !== exp_q[i]) return i;
        end
        if (obs_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic samp_t obs_at(input int i);
        if (i >= 0 && i < obs_q.size()) return obs_q[i];
        return 'x;
    endfunction

    function automatic samp_t exp_at(input int i);
        if (i >= 0 && i < exp_q.size()) return exp_q[i];
        return 'x;
    endfunction

    task automatic clear_sb();
        obs_q.delete();
        exp_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
        acc_cnt  = 0;
    endtask

    task automatic send_beat(input int v, input logic l);
        int waitc;
        waitc    = 0;
        S_TDATA  = mk(v);
        S_TLAST  = l;
        S_TVALID = 1'b1;
        forever begin
            @(negedge SYS_CLK);
            if (S_TREADY) break;
            waitc++;
            if (waitc > 5000) begin
                checks++;
                failures++;
                $display("FAIL send_timeout: beat %0d not accepted after %0d cycles, want accepted", v, waitc);
                break;
            end
        end
        @(posedge SYS_CLK);
        #1;
        S_TVALID = 1'b0;
        S_TLAST  = 1'b0;
    endtask

    task automatic send_frame(input int base, input int n, input logic with_last);
        @(posedge SYS_CLK);
        #1;
        for (int k = 0; k < n; k++) begin
            send_beat(base + k, with_last && (k == n - 1));
        end
    endtask

    task automatic expect_frame(input int base, input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({k == n - 1, mk(base + k)});
        end
    endtask

    task automatic wait_outputs(input int n);
        int w;
        w = 0;
        while (obs_q.size() < n && w < 20000) begin
            @(negedge SYS_CLK);
            w++;
        end
        repeat (8) @(negedge SYS_CLK);
    endtask

    task automatic test_reset();
        SYS_RSTN  = 1'b0;
        S_TVALID  = 1'b0;
        S_TLAST   = 1'b0;
        S_TDATA   = '0;
        OUT_READY = 1'b0;
        repeat (3) @(posedge SYS_CLK);
        @(negedge SYS_CLK);
        checks++;
        if (S_TREADY !== 1'b0) begin
            failures++;
            $display("FAIL rst_tready: got %b want 0", S_TREADY);
        end
        checks++;
        if ({DATA_OUT_VALID, DATA_OUT_LAST, FRAME_DONE, FRAME_ERR} !== 4'b0000) begin
            failures++;
            $display("FAIL rst_flags: got v/l/d/e=%b want 0000",
                     {DATA_OUT_VALID, DATA_OUT_LAST, FRAME_DONE, FRAME_ERR});
        end
        checks++;
        if ({I_DATA_OUT, Q_DATA_OUT} !== '0) begin
            failures++;
            $display("FAIL rst_data: got I=%h Q=%h want 0", I_DATA_OUT, Q_DATA_OUT);
        end
        checks++;
        if (FRAME_CNT !== 16'd0) begin
            failures++;
            $display("FAIL rst_frame_cnt: got %0d want 0", FRAME_CNT);
        end
        @(posedge SYS_CLK);
        #1;
        SYS_RSTN = 1'b1;
        @(negedge SYS_CLK);
        checks++;
        if (S_TREADY !== 1'b0) begin
            failures++;
            $display("FAIL rel_tready_early: got %b want 0", S_TREADY);
        end
        @(negedge SYS_CLK);
        checks++;
        if (S_TREADY !== 1'b1) begin
            failures++;
            $display("FAIL rel_tready: got %b want 1", S_TREADY);
        end
    endtask

    task automatic test_good_frame();
        int idx;
        clear_sb();
        OUT_READY = 1'b1;
        expect_frame(0, FL);
        send_frame(0, FL, 1'b1);
        @(negedge SYS_CLK);
        checks++;
        if ({FRAME_DONE, DATA_OUT_VALID} !== 2'b10) begin
            failures++;
            $display("FAIL good_done_cycle: got done/valid=%b want 10", {FRAME_DONE, DATA_OUT_VALID});
        end
        @(negedge SYS_CLK);
        checks++;
        if ({DATA_OUT_VALID, DATA_OUT_LAST, Q_DATA_OUT, I_DATA_OUT} !== {1'b1, exp_q[0]}) begin
            failures++;
            $display("FAIL good_first_valid: got v=%b %h want v=1 %h", DATA_OUT_VALID,
                     {DATA_OUT_LAST, Q_DATA_OUT, I_DATA_OUT}, exp_q[0]);
        end
        exp_frames++;
        wait_outputs(FL);
        idx = first_diff();
        checks++;
        if (idx >= 0) begin
            failures++;
            $display("FAIL good_seq: at %0d got %h (n=%0d) want %h (n=%0d)", idx, obs_at(idx),
                     obs_q.size(), exp_at(idx), exp_q.size());
        end
        checks++;
        if (done_cnt != 1 || err_cnt != 0) begin
            failures++;
            $display("FAIL good_pulses: got done=%0d err=%0d want done=1 err=0", done_cnt, err_cnt);
        end
        checks++;
        if (FRAME_CNT !== 16'(exp_frames)) begin
            failures++;
            $display("FAIL good_frame_cnt: got %0d want %0d", FRAME_CNT, exp_frames);
        end
    endtask

    task automatic test_early_last();
        int idx;
        clear_sb();
        OUT_READY = 1'b1;
`ifndef FRAME_ERR_DROP_EN
        expect_frame(1000, 100);
`endif
        expect_frame(2000, FL);
        send_frame(1000, 100, 1'b1);
        @(negedge SYS_CLK);
        checks++;
        if (FRAME_ERR !== 1'b1) begin
            failures++;
            $display("FAIL early_err_cycle: got %b want 1", FRAME_ERR);
        end
        send_frame(2000, FL, 1'b1);
        exp_frames++;
        wait_outputs(exp_q.size());
        idx = first_diff();
        checks++;
        if (idx >= 0) begin
            failures++;
            $display("FAIL early_seq: at %0d got %h (n=%0d) want %h (n=%0d)", idx, obs_at(idx),
                     obs_q.size(), exp_at(idx), exp_q.size());
        end
        checks++;
        if (done_cnt != 1 || err_cnt != 1) begin
            failures++;
            $display("FAIL early_pulses: got done=%0d err=%0d want done=1 err=1", done_cnt, err_cnt);
        end
        checks++;
        if (FRAME_CNT !== 16'(exp_frames)) begin
            failures++;
            $display("FAIL early_frame_cnt: got %0d want %0d", FRAME_CNT, exp_frames);
        end
    endtask

    task automatic test_missing_last();
        int idx;
        clear_sb();
        OUT_READY = 1'b1;
`ifndef FRAME_ERR_DROP_EN
        expect_frame(3000, FL);
`endif
        expect_frame(5000, FL);
        send_frame(3000, FL, 1'b0);
        @(negedge SYS_CLK);
        checks++;
        if (FRAME_ERR !== 1'b1) begin
            failures++;
            $display("FAIL missing_err_cycle: got %b want 1", FRAME_ERR);
        end
        send_frame(4000, 20, 1'b1);
        send_frame(5000, FL, 1'b1);
        exp_frames++;
        wait_outputs(exp_q.size());
        idx = first_diff();
        checks++;
        if (idx >= 0) begin
            failures++;
            $display("FAIL missing_seq: at %0d got %h (n=%0d) want %h (n=%0d)", idx, obs_at(idx),
                     obs_q.size(), exp_at(idx), exp_q.size());
        end
        checks++;
        if (done_cnt != 1 || err_cnt != 1) begin
            failures++;
            $display("FAIL missing_pulses: got done=%0d err=%0d want done=1 err=1", done_cnt, err_cnt);
        end
        checks++;
        if (FRAME_CNT !== 16'(exp_frames)) begin
            failures++;
            $display("FAIL missing_frame_cnt: got %0d want %0d", FRAME_CNT, exp_frames);
        end
    endtask

    task automatic test_backpressure();
        int idx;
        clear_sb();
        OUT_READY = 1'b0;
        expect_frame(10000, FL);
        expect_frame(11000, FL);
        expect_frame(12000, FL);
        fork
            begin
                send_frame(10000, FL, 1'b1);
                send_frame(11000, FL, 1'b1);
                send_frame(12000, FL, 1'b1);
            end
            begin
                int w;
                w = 0;
                while (acc_cnt < FD + 1 && w < 5000) begin
                    @(negedge SYS_CLK);
                    w++;
                end
                repeat (20) @(negedge SYS_CLK);
                // A full buffer plus the one sample parked in the output register.
                checks++;
                if (acc_cnt != FD + 1 || S_TREADY !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_full: got accepted=%0d tready=%b want accepted=%0d tready=0",
                             acc_cnt, S_TREADY, FD + 1);
                end
                checks++;
                if (FRAME_CNT !== 16'(exp_frames + 2) || DATA_OUT_VALID !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_stalled: got cnt=%0d valid=%b want cnt=%0d valid=1",
                             FRAME_CNT, DATA_OUT_VALID, exp_frames + 2);
                end
                @(posedge SYS_CLK);
                #1;
                OUT_READY = 1'b1;
                @(negedge SYS_CLK);
                checks++;
                if (S_TREADY !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_read_cycle_tready: got %b want 0", S_TREADY);
                end
                @(negedge SYS_CLK);
                checks++;
                if (S_TREADY !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_reopen_tready: got %b want 1", S_TREADY);
                end
            end
        join
        exp_frames += 3;
        wait_outputs(3 * FL);
        idx = first_diff();
        checks++;
        if (idx >= 0) begin
            failures++;
            $display("FAIL bp_seq: at %0d got %h (n=%0d) want %h (n=%0d)", idx, obs_at(idx),
                     obs_q.size(), exp_at(idx), exp_q.size());
        end
        checks++;
        if (FRAME_CNT !== 16'(exp_frames) || done_cnt != 3) begin
            failures++;
            $display("FAIL bp_frame_cnt: got cnt=%0d done=%0d want cnt=%0d done=3",
                     FRAME_CNT, done_cnt, exp_frames);
        end
    endtask

    task automatic test_output_stall();
        int idx;
        int hold_bad;
        clear_sb();
        hold_bad  = 0;
        OUT_READY = 1'b0;
        expect_frame(0, FL);
        fork
            send_frame(0, FL, 1'b1);
            begin
                samp_t prev;
                samp_t cur;
                logic  pv;
                logic  pr;
                int    w;
                pv   = 1'b0;
                pr   = 1'b0;
                prev = '0;
                w    = 0;
                while (obs_q.size() < FL && w < 20000) begin
                    @(posedge SYS_CLK);
                    #1;
                    OUT_READY = 1'($urandom_range(0, 1));
                    @(negedge SYS_CLK);
                    cur = {DATA_OUT_LAST, Q_DATA_OUT, I_DATA_OUT};
                    if (pv && !pr && (DATA_OUT_VALID !== 1'b1 || cur !== prev)) hold_bad++;
                    pv   = DATA_OUT_VALID;
                    pr   = OUT_READY;
                    prev = cur;
                    w++;
                end
                OUT_READY = 1'b1;
            end
        join
        exp_frames++;
        wait_outputs(FL);
        checks++;
        if (hold_bad != 0) begin
            failures++;
            $display("FAIL stall_hold: got %0d stalled cycles with changed output want 0", hold_bad);
        end
        idx = first_diff();
        checks++;
        if (idx >= 0) begin
            failures++;
            $display("FAIL stall_seq: at %0d got %h (n=%0d) want %h (n=%0d)", idx, obs_at(idx),
                     obs_q.size(), exp_at(idx), exp_q.size());
        end
        checks++;
        if (FRAME_CNT !== 16'(exp_frames)) begin
            failures++;
            $display("FAIL stall_frame_cnt: got %0d want %0d", FRAME_CNT, exp_frames);
        end
    endtask

    task automatic test_reset_mid_frame();
        int idx;
        clear_sb();
        OUT_READY = 1'b1;
        send_frame(30000, 301, 1'b0);
        SYS_RSTN = 1'b0;
        @(posedge SYS_CLK);
        #1;
        SYS_RSTN = 1'b1;
        @(negedge SYS_CLK);
        checks++;
        if ({DATA_OUT_VALID, DATA_OUT_LAST, FRAME_DONE, FRAME_ERR, S_TREADY} !== 5'b0 ||
            {I_DATA_OUT, Q_DATA_OUT} !== '0 || FRAME_CNT !== 16'd0) begin
            failures++;
            $display("FAIL midrst_outputs: got v/l/d/e/r=%b I=%h Q=%h cnt=%0d want all 0",
                     {DATA_OUT_VALID, DATA_OUT_LAST, FRAME_DONE, FRAME_ERR, S_TREADY},
                     I_DATA_OUT, Q_DATA_OUT, FRAME_CNT);
        end
        exp_frames = 0;
        expect_frame(31000, FL);
        send_frame(31000, FL, 1'b1);
        exp_frames++;
        wait_outputs(FL);
        idx = first_diff();
        checks++;
        if (idx >= 0) begin
            failures++;
            $display("FAIL midrst_seq: at %0d got %h (n=%0d) want %h (n=%0d)", idx, obs_at(idx),
                     obs_q.size(), exp_at(idx), exp_q.size());
        end
        checks++;
        if (FRAME_CNT !== 16'(exp_frames) || done_cnt != 1 || err_cnt != 0) begin
            failures++;
            $display("FAIL midrst_counts: got cnt=%0d done=%0d err=%0d want cnt=1 done=1 err=0",
                     FRAME_CNT, done_cnt, err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_early_last();
        test_missing_last();
        test_backpressure();
        test_output_stall();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_frame_sink.md
# fft_frame_sink

Receive-side companion of the FFT input framer. Accepts the AXI-Stream result frames produced by the FFT/IFFT core (48-bit complex beats with tlast) on SYS_CLK and checks every frame against FFT_LEN. Buffers complete frames store-and-forward, then emits them as split I/Q samples with a valid/ready output handshake. Sits between the FFT/IFFT core's master data port and the downstream I/Q calibration logic.

## Interface
- BIT_NUM, 24, width of each I and Q component.
- FFT_LEN, 512, expected beats per frame (≥2).
- FIFO_DEPTH, 1024, buffer depth in beats; power of 2; must be ≥ FFT_LEN.

- SYS_CLK  in  1  single clock for all logic.
- SYS_RSTN  in  1  synchronous, active-low reset.
- S_TDATA  in  2*BIT_NUM  beat from core: I = [BIT_NUM-1:0], Q = [2*BIT_NUM-1:BIT_NUM].
- S_TVALID  in  1  beat valid.
- S_TLAST  in  1  core's end-of-frame marker.
- S_TREADY  out  1  sink can accept a beat.
- OUT_READY  in  1  downstream accepts output sample.
- I_DATA_OUT  out  BIT_NUM  real component.
- Q_DATA_OUT  out  BIT_NUM  imaginary component.
- DATA_OUT_VALID  out  1  output sample valid.
- DATA_OUT_LAST  out  1  output sample closes a frame.
- FRAME_DONE  out  1  one-cycle pulse: good frame committed.
- FRAME_ERR  out  1  one-cycle pulse: frame length error detected.
- FRAME_CNT  out  16  good frames committed; saturates at 16'hFFFF.

## Operation
- Beat accepted when S_TVALID && S_TREADY. Stored in buffer at wr_ptr with a last bit; wr_ptr increments.
- Pointers: wr_ptr, cmt_ptr, rd_ptr. All are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- Fill level = wr_ptr − rd_ptr.
- Only beats below cmt_ptr are readable.
- State machine: RECV (reset state) and RESYNC.
- RECV: sample_cnt counts accepted beats from 0.
  - Beat with sample_cnt == FFT_LEN-1 and S_TLAST=1 is a good close. Stored last=1, cmt_ptr ← wr_ptr+1, FRAME_DONE pulse, FRAME_CNT+1, sample_cnt ← 0.
  - Beat with S_TLAST=1 and sample_cnt < FFT_LEN-1 is an early-last error. FRAME_ERR pulse, frame closed per Configuration, sample_cnt ← 0, stay RECV.
  - Beat with sample_cnt == FFT_LEN-1 and S_TLAST=0 is a missing-last error. FRAME_ERR pulse, frame closed per Configuration, sample_cnt ← 0, go RESYNC.
- RESYNC: S_TREADY=1. Accepted beats are discarded (not written). The beat with S_TLAST=1 is discarded and the state returns to RECV.
- S_TREADY in RECV = (fill level < FIFO_DEPTH).
  - The uncommitted frame is ≤ FFT_LEN ≤ FIFO_DEPTH, so committed data always drains and deadlock cannot occur.
- Output register loads buffer[rd_ptr] (I, Q, last) and rd_ptr increments when rd_ptr != cmt_ptr and (!DATA_OUT_VALID || OUT_READY).
- Output register holds its value while DATA_OUT_VALID && !OUT_READY.
- DATA_OUT_VALID drops when consumed and no committed data remains.

## Timing
- Reset values:
  - S_TREADY=0 during reset, 1 on the first cycle after release.
  - I_DATA_OUT=0, Q_DATA_OUT=0, DATA_OUT_VALID=0, DATA_OUT_LAST=0, FRAME_DONE=0, FRAME_ERR=0, FRAME_CNT=0.
  - All pointers 0, state RECV, sample_cnt 0.
- Reset mid-frame discards all buffered and uncommitted data. No pulse is issued.
- Closing-beat handshake at edge N:
  - FRAME_DONE/FRAME_ERR high in cycle N+1.
  - cmt_ptr updated at N+1.
  - With an empty buffer and OUT_READY=1, the first DATA_OUT_VALID is in cycle N+2.
- Sustained output throughput is 1 sample/cycle while committed data exists.
- Simultaneous write and read in one cycle is allowed. The fill level accounts for both.
- Full buffer with a read in the same cycle: S_TREADY stays 0 that cycle (registered-full view) and rises the next cycle.

## Configuration
- FRAME_ERR_DROP_EN defined:
  - An errored frame is rolled back: wr_ptr ← cmt_ptr.
  - Its beats never appear on the output.
  - FRAME_CNT is unchanged.
- FRAME_ERR_DROP_EN undefined:
  - An errored frame is committed as received, with last=1 on its closing beat: cmt_ptr ← wr_ptr+1.
  - FRAME_ERR still pulses; FRAME_CNT is unchanged.
  - In RESYNC, discarded beats remain dropped in both builds.

## Test plan
- Good frame: 512 beats, data = {Q=k, I=−k}, tlast on beat 511, OUT_READY=1 -> FRAME_DONE once, FRAME_CNT=1, 512 outputs in order with I=−k, Q=k, DATA_OUT_LAST only on the 512th output, first valid 2 cycles after the last beat.
- Early last: tlast on beat 99 then a good 512-beat frame -> FRAME_ERR once, FRAME_CNT=1. With FRAME_ERR_DROP_EN only the 512 good samples are output. Without it, 100 + 512 samples are output, with LAST on #100 and #612.
- Missing last: 512 beats without tlast, 20 extra beats ending in tlast, then a good frame -> FRAME_ERR at beat 511, the 20 beats are discarded, the next frame is good, FRAME_CNT=1.
- Backpressure: OUT_READY=0, three good frames sent back to back -> S_TREADY falls after 1024 stored beats; raising OUT_READY drains all 1536 samples without loss or duplication, FRAME_CNT=3.
- Output stall: OUT_READY toggled randomly during a frame -> I/Q hold while valid && !ready, sequence 0..511 intact.
- Reset mid-frame: SYS_RSTN low for 1 cycle after beat 300 -> all outputs 0, then the next good frame is output exactly, FRAME_CNT=1.
